// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

    localparam logic [3:0]  AN_OFF     = 4'b1111;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/sseg_next_digit.sv
// Finds the next enabled digit after the current one, wrapping modulo 4.
module sseg_next_digit
    import sseg_pkg::*;
(
    input  digit_idx_t       i_sel,
    input  logic [3:0]       i_mask,
    output digit_idx_t       o_next_c,
    output logic             o_wrap_c,
    output logic             o_none_c
);

    digit_idx_t w_next;
    digit_idx_t w_cand;

    // Walk from farthest to nearest so the nearest enabled candidate wins; k=4 is self.
    always_comb begin
        w_next = i_sel;
        w_cand = i_sel;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            w_cand = i_sel + digit_idx_t'(k);
            if (i_mask[w_cand]) begin
                w_next = w_cand;
            end
        end
    end

    assign o_next_c = w_next;
    assign o_wrap_c = (w_next <= i_sel);
    assign o_none_c = (i_mask == 4'b0000);

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed 4-digit scan with blanking, brightness PWM, digit masking and frame pulse.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] brightness,
    input  logic [3:0] digit_mask,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned CNT_W   = $clog2(TICK_DIV);
    localparam int unsigned ON_STEP = (TICK_DIV - BLANK_CYCLES) / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_sel;
    logic [2:0]       r_bright;
    logic [3:0]       r_an;
    logic             r_frame;

    logic [CNT_W-1:0] w_cnt_next;
    digit_idx_t       w_sel_next;
    logic [2:0]       w_bright_next;
    logic [3:0]       w_an_next;
    logic             w_frame_next;
    logic             w_adv;
    logic             w_lit;
    logic [31:0]      w_off;
    digit_idx_t       w_nd_next;
    logic             w_nd_wrap;
    logic             w_nd_none;

    sseg_next_digit u_next_digit (
        .i_sel    (r_sel),
        .i_mask   (digit_mask),
        .o_next_c (w_nd_next),
        .o_wrap_c (w_nd_wrap),
        .o_none_c (w_nd_none)
    );

    // Next-state values; an is derived from the same next cnt/sel so all stay aligned.
    always_comb begin
        w_adv         = en && (r_cnt == CNT_LAST);
        w_cnt_next    = r_cnt;
        if (en) begin
            w_cnt_next = w_adv ? '0 : r_cnt + CNT_W'(1);
        end
        w_sel_next    = w_adv ? w_nd_next : r_sel;
        w_bright_next = (en && (r_cnt == '0)) ? brightness : r_bright;
        w_frame_next  = w_adv && w_nd_wrap && !w_nd_none;

        w_off = 32'(w_cnt_next) - 32'(BLANK_CYCLES);
        w_lit = (32'(w_cnt_next) >= 32'(BLANK_CYCLES)) &&
                ((w_bright_next == 3'd7) ||
                 (w_off < 32'(ON_STEP) * (32'(w_bright_next) + 32'd1)));

        w_an_next = AN_OFF;
        if (en && digit_mask[w_sel_next] && w_lit) begin
            w_an_next[w_sel_next] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sel    <= '0;
            r_bright <= 3'd7;
            r_an     <= AN_OFF;
            r_frame  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_sel    <= w_sel_next;
            r_bright <= w_bright_next;
            r_an     <= w_an_next;
            r_frame  <= w_frame_next;
        end
    end

    assign digit_sel  = r_sel;
    assign an         = r_an;
    assign frame_tick = r_frame;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan with TICK_DIV=16, BLANK_CYCLES=2 (one PWM step per cycle).
module tb_sseg_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en;
    logic [2:0] brightness;
    logic [3:0] digit_mask;
    logic [1:0] digit_sel;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    sseg_scan #(.TICK_DIV(16), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .brightness (brightness),
        .digit_mask (digit_mask),
        .digit_sel  (digit_sel),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    function automatic logic [3:0] mk_an(input int s, input bit lit);
        logic [3:0] e;
        e = 4'b1111;
        if (lit) e[s] = 1'b0;
        return e;
    endfunction

    initial begin
        int c;
        int s;
        bit lit;
        en = 1'b0; brightness = 3'd7; digit_mask = 4'b1111;
        #1 rst = 1'b1;
        #2;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sel", 32'(digit_sel), 0);
        chk("rst_ft", 32'(frame_tick), 0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1;

        // full-mask scan at full brightness
        for (int i = 0; i < 64; i++) begin
            step();
            c = k % 16; s = (k / 16) % 4;
            chk("t1_sel", 32'(digit_sel), 32'(s));
            chk("t1_an", 32'(an), 32'(mk_an(s, c >= 2)));
            chk("t1_ft", 32'(frame_tick), 32'(k == 64));
        end

        // brightness change mid-slot takes effect next slot
        repeat (7) step();
        brightness = 3'd3;
        for (int i = 0; i < 24; i++) begin
            step();
            c = k % 16;
            s = (k < 80) ? 0 : 1;
            lit = (k < 80) ? (c >= 2) : (c >= 2 && c <= 5);
            chk("t2_sel", 32'(digit_sel), 32'(s));
            chk("t2_an", 32'(an), 32'(mk_an(s, lit)));
            if (k == 90) brightness = 3'd7;
        end

        // mask 0101 skips digits 1 and 3
        digit_mask = 4'b0101;
        for (int i = 0; i < 64; i++) begin
            step();
            c = k % 16;
            s = ((((k - 96) / 16) % 2) == 0) ? 2 : 0;
            chk("t3_sel", 32'(digit_sel), 32'(s));
            chk("t3_an", 32'(an), 32'(mk_an(s, c >= 2)));
            chk("t3_ft", 32'(frame_tick), 32'(k == 112 || k == 144));
        end

        // empty mask: dark, held, no tick
        digit_mask = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t4_sel", 32'(digit_sel), 0);
            chk("t4_an", 32'(an), 32'hF);
            chk("t4_ft", 32'(frame_tick), 0);
        end

        // single enabled digit ticks every slot after reaching it
        digit_mask = 4'b1000;
        for (int i = 0; i < 48; i++) begin
            step();
            c = k % 16;
            chk("t5_sel", 32'(digit_sel), 3);
            chk("t5_an", 32'(an), 32'(mk_an(3, c >= 2)));
            chk("t5_ft", 32'(frame_tick), 32'(k == 208 || k == 224));
        end

        // enable drop while digit 1 is lit at cnt 9
        digit_mask = 4'b1111;
        repeat (26) step();
        chk("t6_pre_sel", 32'(digit_sel), 1);
        chk("t6_pre_an", 32'(an), 32'hD);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            chk("t6_off_an", 32'(an), 32'hF);
            chk("t6_off_sel", 32'(digit_sel), 1);
            chk("t6_off_ft", 32'(frame_tick), 0);
        end
        en = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); @(negedge clk);
            s = (j <= 6) ? 1 : 2;
            chk("t6_on_sel", 32'(digit_sel), 32'(s));
            chk("t6_on_an", 32'(an), 32'(mk_an(s, j <= 6 || j == 9)));
        end

        // asynchronous reset between edges
        #1 rst = 1'b1;
        #1;
        chk("t7_an", 32'(an), 32'hF);
        chk("t7_sel", 32'(digit_sel), 0);
        chk("t7_ft", 32'(frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t7_c1_an", 32'(an), 32'hF);
        step();
        chk("t7_c2_an", 32'(an), 32'hE);
        chk("t7_c2_sel", 32'(digit_sel), 0);
        repeat (14) step();
        chk("t7_adv_sel", 32'(digit_sel), 1);
        chk("t7_adv_ft", 32'(frame_tick), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
